apb2axi_rd_resp_collector: RTL and testbench
============================================

// Module: apb2axi_rd_resp_collector
// PURPOSE
// AXI R-channel front end of the read-response path, on the AXI clock. Accepts R beats, matches RID to tag,
// counts beats against the length registered at AR issue, and pushes one rdf_entry_t per beat into the RDF FIFO.
// At transaction end it pushes one completion_entry_t into the completion FIFO. Both FIFOs are then drained
// on the APB side by apb2axi_response_handler.
// PARAMETERS
// TAG_W       TAG_W (pkg)      tag width = AXI ID width; N_TAG = 1<<TAG_W
// DATA_W      AXI_DATA_W (pkg) R data width
// LEN_W       8                AXI ARLEN width; beat counter is LEN_W+1 bits
// PORTS
// aclk             in   1       AXI clock
// aresetn          in   1       async active-low reset
// rd_issue_vld     in   1       AR handshake occurred (1-cycle pulse)
// rd_issue_tag     in   TAG_W   ARID of issued read
// rd_issue_len     in   LEN_W   ARLEN (beats-1)
// rvalid/rready    in/out 1     AXI R handshake
// rid              in   TAG_W   AXI RID
// rdata            in   DATA_W  AXI RDATA
// rresp            in   2       AXI RRESP
// rlast            in   1       AXI RLAST
// rdf_push_valid   out  1       RDF FIFO write strobe
// rdf_push_payload out  rdf_entry_t {tag,data,resp,last}
// rdf_push_ready   in   1       RDF FIFO not full
// cq_push_valid    out  1       completion FIFO write strobe
// cq_push_data     out  completion_entry_t {tag,is_write=0,resp,error}
// cq_push_ready    in   1       completion FIFO not full
// err_unexp_tag    out  1       1-cycle pulse: beat accepted for an inactive tag
// err_reissue      out  1       1-cycle pulse: issue on an already-active tag
// BEHAVIOUR
// - Reset: all tags INACTIVE, counters 0, agg resp 0; cq_push_valid=0, err_* = 0.
//   rready and rdf_push_valid are then 0, since they are combinational and gated by tag state.
// - Per-tag state: INACTIVE -> ACTIVE on rd_issue_vld; ACTIVE -> INACTIVE when its final beat is accepted.
//   Per tag, also hold exp_len (LEN_W), beat_cnt (LEN_W+1) and agg_resp (2).
// - Final beat: (rlast==1) OR (beat_cnt==exp_len).
//   - rlast with beat_cnt<exp_len: early last, error=1.
//   - beat_cnt==exp_len with rlast==0: missing last, error=1, treated as final.
// - Beat path, combinational, 0 latency, ACTIVE tag:
//   - rdf_push_valid = rvalid.
//   - rdf_push_payload = {rid, rdata, rresp, final}.
//   - rready = rdf_push_ready AND (!final OR cq slot free).
// - cq slot free = !cq_push_valid OR cq_push_ready.
// - Inactive-tag beat: rready=1, beat dropped, rdf_push_valid=0, err_unexp_tag pulses the next cycle.
// - Accept (rvalid&&rready): beat_cnt+1 and agg_resp = max(agg_resp, rresp), numeric max so 11>10>01>00.
// - Final accept: in the next cycle, cq_push_valid=1 and cq_push_data={tag, 0, max(agg_resp,rresp), error}.
//   - Tag returns to INACTIVE, beat_cnt and agg_resp clear.
//   - cq_push_valid holds with stable data until cq_push_ready; it is a single-entry output register.
// - rd_issue_vld on an ACTIVE tag whose final beat is not accepted this cycle: ignored, err_reissue pulses.
// - rd_issue_vld on a tag whose final beat is accepted in the same cycle: legal, issue wins, tag stays ACTIVE.
// - Issue and beat on the same tag in the same cycle with the tag INACTIVE: beat is unexpected, issue is registered.
// - exp_len=0: the first beat is final. exp_len=255: the counter reaches 255 without overflow (LEN_W+1 bits).
// - Async reset mid-transaction: all state is lost, no completion emitted, any held cq entry is discarded.
// - Interleaved RIDs across tags are fully supported; beats within one tag stay in order.
// STRUCTURE
// - apb2axi_pkg gains: AXI_LEN_W=8; RESP_OKAY/EXOKAY/SLVERR/DECERR; rd_trk_t {active,exp_len,beat_cnt,agg_resp}.
// - apb2axi_pkg completion_entry_t gains an error bit if it lacks one.
// - rdf_entry_t is shared, unchanged.
// - One sub-module, apb2axi_rd_tag_tracker: N_TAG x rd_trk_t table with issue port, beat-update port,
//   and combinational lookup by rid.
// - Top level: handshake gating plus the cq output register.
// TESTING
// 1 Issue tag3 len=3, send 4 beats OKAY, rlast on beat 4 -> 4 RDF pushes, last=1 only on beat 4;
//   1 cq push {tag3,0,OKAY,err=0} one cycle after beat 4.
// 2 Tags 1(len1) and 2(len1), beats interleaved 1,2,1,2 with beat 2 of tag1 SLVERR
//   -> cq tag1 resp=10, cq tag2 resp=00, in rlast order.
// 3 rdf_push_ready=0 for 5 cycles mid-burst -> rready=0, no beat lost or duplicated, order preserved.
// 4 cq_push_ready=0, tag0 final beat done, then tag1 final beat arrives
//   -> tag1 last beat stalled (rready=0) until cq drains; tag0 cq data stable throughout.
// 5 Issue len=2, rlast on beat 2 -> cq error=1.
//   Separately, issue len=0 without rlast -> cq error=1, tag INACTIVE.
// 6 Beat on inactive tag5 -> rready=1, no RDF push, err_unexp_tag pulses.
//   Reissue on active tag -> err_reissue.
//   aresetn low mid-burst -> cq_push_valid=0, all tags INACTIVE.

Source files
------------

// File: rtl/apb2axi_rd_resp_collector_pkg.sv
// Shared types and constants for the AXI read-response collector.
package apb2axi_rd_resp_collector_pkg;

  localparam int TAG_W      = 4;
  localparam int N_TAG      = 1 << TAG_W;
  localparam int AXI_DATA_W = 32;
  localparam int AXI_LEN_W  = 8;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // One R beat as written into the read-data FIFO.
  typedef struct packed {
    logic [TAG_W-1:0]      tag;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } rdf_entry_t;

  // One finished transaction as written into the completion FIFO.
  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             is_write;
    logic [1:0]       resp;
    logic             error;
  } completion_entry_t;

  // Per-tag read tracking record.
  typedef struct packed {
    logic                 active;
    logic [AXI_LEN_W-1:0] exp_len;
    logic [AXI_LEN_W:0]   beat_cnt;
    logic [1:0]           agg_resp;
  } rd_trk_t;

  // Severity merge of two AXI responses; the encoding is ordered so a numeric max works.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/apb2axi_rd_resp_collector_if.sv
// Bus bundle for the read-response collector: AR issue notification, AXI R channel,
// RDF push port, completion push port and error pulses.
interface apb2axi_rd_resp_collector_if;
  import apb2axi_rd_resp_collector_pkg::*;

  logic                  rd_issue_vld;
  logic [TAG_W-1:0]      rd_issue_tag;
  logic [AXI_LEN_W-1:0]  rd_issue_len;

  logic                  rvalid;
  logic                  rready;
  logic [TAG_W-1:0]      rid;
  logic [AXI_DATA_W-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;

  logic                  rdf_push_valid;
  rdf_entry_t            rdf_push_payload;
  logic                  rdf_push_ready;

  logic                  cq_push_valid;
  completion_entry_t     cq_push_data;
  logic                  cq_push_ready;

  logic                  err_unexp_tag;
  logic                  err_reissue;

  modport slave (
    input  rd_issue_vld, rd_issue_tag, rd_issue_len,
    input  rvalid, rid, rdata, rresp, rlast,
    input  rdf_push_ready, cq_push_ready,
    output rready, rdf_push_valid, rdf_push_payload,
    output cq_push_valid, cq_push_data,
    output err_unexp_tag, err_reissue
  );

  modport master (
    output rd_issue_vld, rd_issue_tag, rd_issue_len,
    output rvalid, rid, rdata, rresp, rlast,
    output rdf_push_ready, cq_push_ready,
    input  rready, rdf_push_valid, rdf_push_payload,
    input  cq_push_valid, cq_push_data,
    input  err_unexp_tag, err_reissue
  );

endinterface

// File: rtl/apb2axi_rd_resp_collector_tag_tracker.sv
// Per-tag outstanding-read table: registered on AR issue, advanced on each accepted
// beat, cleared on the final beat. Lookup by RID is combinational.
module apb2axi_rd_resp_collector_tag_tracker
  import apb2axi_rd_resp_collector_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 issue_vld_i,
  input  logic [TAG_W-1:0]     issue_tag_i,
  input  logic [AXI_LEN_W-1:0] issue_len_i,
  input  logic                 upd_vld_i,
  input  logic [TAG_W-1:0]     upd_tag_i,
  input  logic                 upd_final_i,
  input  logic [1:0]           upd_resp_i,
  input  logic [TAG_W-1:0]     lookup_tag_i,
  output rd_trk_t              lookup_o,
  output logic                 issue_rej_o
);

  rd_trk_t table_q [N_TAG];
  rd_trk_t table_d [N_TAG];
  logic    retire_same_tag;

  assign lookup_o = table_q[lookup_tag_i];

  // An issue is only refused when the tag stays busy; a tag retiring this cycle may be reused.
  always_comb begin
    retire_same_tag = upd_vld_i && upd_final_i && (upd_tag_i == issue_tag_i);
    issue_rej_o     = issue_vld_i && table_q[issue_tag_i].active && !retire_same_tag;
  end

  // Next-state table: beat update first, then an accepted issue overrides the same entry.
  always_comb begin
    table_d = table_q;
    if (upd_vld_i) begin
      if (upd_final_i) begin
        table_d[upd_tag_i] = '0;
      end else begin
        table_d[upd_tag_i].beat_cnt = table_q[upd_tag_i].beat_cnt + (AXI_LEN_W+1)'(1);
        table_d[upd_tag_i].agg_resp = resp_max(table_q[upd_tag_i].agg_resp, upd_resp_i);
      end
    end else begin
      table_d[upd_tag_i] = table_q[upd_tag_i];
    end
    if (issue_vld_i && !issue_rej_o) begin
      table_d[issue_tag_i].active   = 1'b1;
      table_d[issue_tag_i].exp_len  = issue_len_i;
      table_d[issue_tag_i].beat_cnt = '0;
      table_d[issue_tag_i].agg_resp = RESP_OKAY;
    end else begin
      table_d[issue_tag_i] = table_d[issue_tag_i];
    end
  end

  // Table register; reset drops every outstanding read.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N_TAG; i++) table_q[i] <= '0;
    end else begin
      table_q <= table_d;
    end
  end

endmodule

// File: rtl/apb2axi_rd_resp_collector.sv
// AXI R-channel collector: tags beats by RID, forwards each accepted beat to the RDF
// FIFO with zero latency, and emits one completion record per finished read through
// a single-entry output register.
module apb2axi_rd_resp_collector
  import apb2axi_rd_resp_collector_pkg::*;
(
  input  logic                          aclk,
  input  logic                          aresetn,
  apb2axi_rd_resp_collector_if.slave    bus
);

  rd_trk_t           trk;
  logic              issue_rej;
  logic              cnt_at_len;
  logic              cnt_below_len;
  logic              beat_final;
  logic              beat_err;
  logic              cq_free;
  logic              rready_c;
  logic              rdf_valid_c;
  logic              accept;
  logic              beat_acc;
  logic              final_acc;
  completion_entry_t cq_d;

  logic              cq_valid_q;
  completion_entry_t cq_data_q;
  logic              err_unexp_q;
  logic              err_reissue_q;

  apb2axi_rd_resp_collector_tag_tracker u_tracker (
    .clk_i        (aclk),
    .rst_ni       (aresetn),
    .issue_vld_i  (bus.rd_issue_vld),
    .issue_tag_i  (bus.rd_issue_tag),
    .issue_len_i  (bus.rd_issue_len),
    .upd_vld_i    (beat_acc),
    .upd_tag_i    (bus.rid),
    .upd_final_i  (beat_final),
    .upd_resp_i   (bus.rresp),
    .lookup_tag_i (bus.rid),
    .lookup_o     (trk),
    .issue_rej_o  (issue_rej)
  );

  assign cq_free = !cq_valid_q || bus.cq_push_ready;

  // Beat classification and handshake gating. The RDF strobe shares the completion-slot
  // gate with rready so a stalled final beat is never written into the RDF twice.
  // Beats for an inactive tag are sunk (rready follows rvalid) and never forwarded.
  always_comb begin
    cnt_at_len    = (trk.beat_cnt == {1'b0, trk.exp_len});
    cnt_below_len = (trk.beat_cnt <  {1'b0, trk.exp_len});
    beat_final    = 1'b0;
    beat_err      = 1'b0;
    rready_c      = 1'b0;
    rdf_valid_c   = 1'b0;
    if (trk.active) begin
      beat_final  = bus.rlast || cnt_at_len;
      beat_err    = (bus.rlast && cnt_below_len) || (!bus.rlast && cnt_at_len);
      rready_c    = bus.rdf_push_ready && (!beat_final || cq_free);
      rdf_valid_c = bus.rvalid && (!beat_final || cq_free);
    end else begin
      rready_c    = bus.rvalid;
    end
    accept    = bus.rvalid && rready_c;
    beat_acc  = accept && trk.active;
    final_acc = beat_acc && beat_final;
  end

  // Completion record built from the final beat, folding its own response into the aggregate.
  always_comb begin
    cq_d.tag      = bus.rid;
    cq_d.is_write = 1'b0;
    cq_d.resp     = resp_max(trk.agg_resp, bus.rresp);
    cq_d.error    = beat_err;
  end

  // Single-entry completion register: loads on final accept, holds until drained.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      cq_valid_q <= 1'b0;
      cq_data_q  <= '0;
    end else if (final_acc) begin
      cq_valid_q <= 1'b1;
      cq_data_q  <= cq_d;
    end else if (bus.cq_push_ready) begin
      cq_valid_q <= 1'b0;
    end
  end

  // One-cycle error pulses for stray beats and refused issues.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_unexp_q   <= 1'b0;
      err_reissue_q <= 1'b0;
    end else begin
      err_unexp_q   <= accept && !trk.active;
      err_reissue_q <= issue_rej;
    end
  end

  assign bus.rready           = rready_c;
  assign bus.rdf_push_valid   = rdf_valid_c;
  assign bus.rdf_push_payload = '{tag: bus.rid, data: bus.rdata, resp: bus.rresp, last: beat_final};
  assign bus.cq_push_valid    = cq_valid_q;
  assign bus.cq_push_data     = cq_data_q;
  assign bus.err_unexp_tag    = err_unexp_q;
  assign bus.err_reissue      = err_reissue_q;

endmodule

// File: tb/tb_apb2axi_rd_resp_collector.sv
// Self-checking bench for apb2axi_rd_resp_collector: table of whole read transactions
// plus hand-written sequences, with RDF and completion scoreboards.
module tb_apb2axi_rd_resp_collector;
  import apb2axi_rd_resp_collector_pkg::*;

  logic aclk = 1'b0;
  logic aresetn;
  always #5 aclk = ~aclk;

  apb2axi_rd_resp_collector_if bus ();

  apb2axi_rd_resp_collector dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  rdf_entry_t        rdf_q [$];
  completion_entry_t cq_q  [$];

  typedef struct {
    int          tag;
    int          len;
    int          nbeats;
    int          last_at;   // beat index carrying rlast, -1 for none
    logic [15:0] resps;     // 2 bits per beat for the first 8 beats, OKAY afterwards
    logic [1:0]  exp_resp;
    logic        exp_err;
  } vec_t;

  vec_t vecs [7];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic issue(input int tag, input int len);
    bus.rd_issue_vld = 1'b1;
    bus.rd_issue_tag = TAG_W'(tag);
    bus.rd_issue_len = AXI_LEN_W'(len);
    @(posedge aclk); #1;
    bus.rd_issue_vld = 1'b0;
  endtask

  task automatic push_cq(input int tag, input logic [1:0] resp, input logic err);
    completion_entry_t e;
    e.tag = TAG_W'(tag); e.is_write = 1'b0; e.resp = resp; e.error = err;
    cq_q.push_back(e);
  endtask

  task automatic send_beat(input int tag, input logic [1:0] resp, input logic last,
                           input logic exp_push, input logic exp_last);
    logic [31:0] d;
    rdf_entry_t  e;
    logic        ok;
    d = $urandom;
    if (exp_push) begin
      e.tag = TAG_W'(tag); e.data = d; e.resp = resp; e.last = exp_last;
      rdf_q.push_back(e);
    end
    bus.rvalid = 1'b1; bus.rid = TAG_W'(tag); bus.rdata = d; bus.rresp = resp; bus.rlast = last;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge aclk);
      if (bus.rready) begin ok = 1'b1; break; end
    end
    check("beat_accepted", ok, 1'b1);
    @(posedge aclk); #1;
    bus.rvalid = 1'b0; bus.rlast = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40; i++) begin
      if (rdf_q.size() == 0 && cq_q.size() == 0) break;
      @(posedge aclk); #1;
    end
    check("scoreboard_drained", 64'(rdf_q.size() + cq_q.size()), 64'd0);
  endtask

  initial begin
    bus.rd_issue_vld = 1'b0; bus.rd_issue_tag = '0; bus.rd_issue_len = '0;
    bus.rvalid = 1'b0; bus.rid = '0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    bus.rdf_push_ready = 1'b1; bus.cq_push_ready = 1'b1;
    aresetn = 1'b0;

    vecs[0] = '{tag: 3, len: 3,   nbeats: 4,   last_at: 3,   resps: 16'h0000, exp_resp: 2'b00, exp_err: 1'b0};
    vecs[1] = '{tag: 2, len: 2,   nbeats: 2,   last_at: 1,   resps: 16'h0000, exp_resp: 2'b00, exp_err: 1'b1};
    vecs[2] = '{tag: 4, len: 0,   nbeats: 1,   last_at: -1,  resps: 16'h0000, exp_resp: 2'b00, exp_err: 1'b1};
    vecs[3] = '{tag: 0, len: 0,   nbeats: 1,   last_at: 0,   resps: 16'h0001, exp_resp: 2'b01, exp_err: 1'b0};
    vecs[4] = '{tag: 7, len: 2,   nbeats: 3,   last_at: 2,   resps: 16'h002C, exp_resp: 2'b11, exp_err: 1'b0};
    vecs[5] = '{tag: 6, len: 1,   nbeats: 2,   last_at: -1,  resps: 16'h0001, exp_resp: 2'b01, exp_err: 1'b1};
    vecs[6] = '{tag: 9, len: 255, nbeats: 256, last_at: 255, resps: 16'h0000, exp_resp: 2'b00, exp_err: 1'b0};

    fork
      // Output monitor: scoreboard pops on every RDF / completion handshake.
      forever begin
        @(negedge aclk);
        if (bus.rdf_push_valid && bus.rdf_push_ready) begin
          if (rdf_q.size() == 0) check("rdf_unexpected_push", 64'(bus.rdf_push_payload), 64'd0);
          else check("rdf_payload", 64'(bus.rdf_push_payload), 64'(rdf_q.pop_front()));
        end
        if (bus.cq_push_valid && bus.cq_push_ready) begin
          if (cq_q.size() == 0) check("cq_unexpected_push", 64'(bus.cq_push_data), 64'd0);
          else check("cq_data", 64'(bus.cq_push_data), 64'(cq_q.pop_front()));
        end
      end
      begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
      end
    join_none

    // Reset state
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_cq_valid", bus.cq_push_valid, 1'b0);
    check("rst_rready", bus.rready, 1'b0);
    check("rst_rdf_valid", bus.rdf_push_valid, 1'b0);
    check("rst_err_unexp", bus.err_unexp_tag, 1'b0);
    check("rst_err_reissue", bus.err_reissue, 1'b0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // Table-driven whole transactions
    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].tag, vecs[v].len);
      for (int i = 0; i < vecs[v].nbeats; i++) begin
        logic [1:0] r;
        logic       is_last;
        r = (i < 8) ? vecs[v].resps[2*i +: 2] : RESP_OKAY;
        is_last = (i == vecs[v].nbeats - 1);
        if (is_last) push_cq(vecs[v].tag, vecs[v].exp_resp, vecs[v].exp_err);
        send_beat(vecs[v].tag, r, (i == vecs[v].last_at), 1'b1, is_last);
      end
      check("cq_latency", bus.cq_push_valid, 1'b1);
      wait_drain();
    end

    // Interleaved tags 1 and 2, SLVERR on tag1's last beat
    issue(1, 1);
    issue(2, 1);
    send_beat(1, RESP_OKAY, 1'b0, 1'b1, 1'b0);
    send_beat(2, RESP_OKAY, 1'b0, 1'b1, 1'b0);
    push_cq(1, RESP_SLVERR, 1'b0);
    send_beat(1, RESP_SLVERR, 1'b1, 1'b1, 1'b1);
    push_cq(2, RESP_OKAY, 1'b0);
    send_beat(2, RESP_OKAY, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // RDF back-pressure mid-burst
    issue(5, 3);
    send_beat(5, RESP_OKAY, 1'b0, 1'b1, 1'b0);
    send_beat(5, RESP_OKAY, 1'b0, 1'b1, 1'b0);
    bus.rdf_push_ready = 1'b0;
    bus.rvalid = 1'b1; bus.rid = TAG_W'(5); bus.rresp = RESP_OKAY; bus.rlast = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("rdf_stall_rready", bus.rready, 1'b0);
    end
    @(posedge aclk); #1;
    bus.rdf_push_ready = 1'b1;
    send_beat(5, RESP_OKAY, 1'b0, 1'b1, 1'b0);
    push_cq(5, RESP_OKAY, 1'b0);
    send_beat(5, RESP_OKAY, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Completion back-pressure: tag1 final beat waits for tag0 record to drain
    bus.cq_push_ready = 1'b0;
    issue(0, 0);
    issue(1, 0);
    push_cq(0, RESP_OKAY, 1'b0);
    send_beat(0, RESP_OKAY, 1'b1, 1'b1, 1'b1);
    bus.rvalid = 1'b1; bus.rid = TAG_W'(1); bus.rresp = RESP_OKAY; bus.rlast = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("cq_stall_rready", bus.rready, 1'b0);
      check("cq_stall_valid", bus.cq_push_valid, 1'b1);
      check("cq_stall_data", 64'(bus.cq_push_data), 64'(cq_q[0]));
    end
    @(posedge aclk); #1;
    bus.cq_push_ready = 1'b1;
    push_cq(1, RESP_DECERR, 1'b0);
    send_beat(1, RESP_DECERR, 1'b1, 1'b1, 1'b1);
    wait_drain();

    // Beats on inactive tags 5 and 4 are sunk and flagged
    for (int k = 0; k < 2; k++) begin
      bus.rvalid = 1'b1; bus.rid = TAG_W'(5 - k); bus.rresp = RESP_OKAY; bus.rlast = 1'b1;
      @(negedge aclk);
      check("unexp_rready", bus.rready, 1'b1);
      check("unexp_no_push", bus.rdf_push_valid, 1'b0);
      @(posedge aclk); #1;
      bus.rvalid = 1'b0; bus.rlast = 1'b0;
      check("unexp_pulse", bus.err_unexp_tag, 1'b1);
      @(posedge aclk); #1;
      check("unexp_pulse_end", bus.err_unexp_tag, 1'b0);
    end

    // Reissue on an active tag
    issue(2, 3);
    check("reissue_first_ok", bus.err_reissue, 1'b0);
    issue(2, 3);
    check("reissue_pulse", bus.err_reissue, 1'b1);
    @(posedge aclk); #1;
    check("reissue_pulse_end", bus.err_reissue, 1'b0);

    // Async reset with a burst in flight and a held completion record
    bus.cq_push_ready = 1'b0;
    issue(6, 0);
    send_beat(2, RESP_OKAY, 1'b0, 1'b1, 1'b0);
    push_cq(6, RESP_OKAY, 1'b0);
    send_beat(6, RESP_OKAY, 1'b1, 1'b1, 1'b1);
    check("pre_reset_cq_held", bus.cq_push_valid, 1'b1);
    aresetn = 1'b0;
    #1;
    check("reset_cq_dropped", bus.cq_push_valid, 1'b0);
    cq_q.delete();
    bus.cq_push_ready = 1'b1;
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk); #1;
    bus.rvalid = 1'b1; bus.rid = TAG_W'(2); bus.rresp = RESP_OKAY; bus.rlast = 1'b0;
    @(negedge aclk);
    check("post_reset_tag_inactive", bus.rdf_push_valid, 1'b0);
    @(posedge aclk); #1;
    bus.rvalid = 1'b0;
    check("post_reset_unexp", bus.err_unexp_tag, 1'b1);
    issue(2, 0);
    check("post_reset_issue_ok", bus.err_reissue, 1'b0);
    push_cq(2, RESP_OKAY, 1'b0);
    send_beat(2, RESP_OKAY, 1'b1, 1'b1, 1'b1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
